// File: rtl/controller.sv
`default_nettype none
// ============================================================================
//  Module   : controller
//  Purpose  : VeriRISC instruction sequencer. Walks an 8-phase instruction
//             cycle and decodes opcode/zero into PC, IR, AC and memory strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module controller #(
  parameter int OPWIDTH = 3,
  parameter int PHWIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPWIDTH-1:0] opcode,
  input  logic               zero,
  output logic [PHWIDTH-1:0] phase,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               inc_pc,
  output logic               data_e,
  output logic               halt
);

  typedef enum logic [PHWIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  localparam logic [OPWIDTH-1:0] c_HLT = 3'd0;
  localparam logic [OPWIDTH-1:0] c_SKZ = 3'd1;
  localparam logic [OPWIDTH-1:0] c_ADD = 3'd2;
  localparam logic [OPWIDTH-1:0] c_AND = 3'd3;
  localparam logic [OPWIDTH-1:0] c_XOR = 3'd4;
  localparam logic [OPWIDTH-1:0] c_LDA = 3'd5;
  localparam logic [OPWIDTH-1:0] c_STO = 3'd6;
  localparam logic [OPWIDTH-1:0] c_JMP = 3'd7;

  state_t r_state;
  state_t w_next_state;
  logic   r_halt;
  logic   w_next_halt;
  logic   w_aluop;
  logic   w_hlt_now;

  assign phase = r_state;

  // Phase counter and sticky halt latch; reset acts immediately, no clock needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INST_ADDR;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_halt  <= w_next_halt;
    end
  end

  // Next-phase logic and per-phase strobe decode.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;

    // The opcode is only qualified by phase where it is actually needed, so
    // an undefined IR during fetch never leaks into the fetch strobes.
    w_aluop   = (opcode == c_ADD) || (opcode == c_AND) ||
                (opcode == c_XOR) || (opcode == c_LDA);
    w_hlt_now = (r_state == OP_ADDR) && (opcode == c_HLT);

    // Once halted the phase parks at OP_FETCH until reset.
    w_next_state = r_halt ? r_state : state_t'(r_state + 3'd1);
    w_next_halt  = r_halt | w_hlt_now;

    unique case (r_state)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
      end
      OP_FETCH: begin
        rd = w_aluop;
      end
      ALU_OP: begin
        rd     = w_aluop;
        inc_pc = (opcode == c_SKZ) && zero;
        ld_pc  = (opcode == c_JMP);
        data_e = (opcode == c_STO);
      end
      STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        inc_pc = (opcode == c_JMP);
        ld_pc  = (opcode == c_JMP);
        wr     = (opcode == c_STO);
        data_e = (opcode == c_STO);
      end
      default: begin
        sel = 1'b0;
      end
    endcase

    // A halted processor drives nothing but the halt flag.
    if (r_halt) begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
      data_e = 1'b0;
    end

    // Halt is visible already during OP_ADDR, before the latch captures it.
    halt = r_halt | w_hlt_now;
  end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controller
//  Purpose  : Directed self-checking bench for the VeriRISC controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

  int total = 0;
  int bad   = 0;

  controller #(.OPWIDTH(3), .PHWIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
  logic [8:0] outs;
  assign outs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (phase !== 3'd0) begin
      bad++;
      $display("FAIL reset_phase got=%0d exp=0", phase);
    end
    total++;
    if (outs !== 9'b100000000) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=%b", outs, 9'b100000000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ADD with opcode/zero undefined through the fetch phases.
  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000000100, 9'b010000000, 9'b010000000, 9'b010010000};
    for (int p = 0; p < 8; p++) begin
      if (p < 4) begin
        opcode = 3'bxxx;
        zero   = 1'bx;
      end else begin
        opcode = 3'd2;
        zero   = 1'b0;
      end
      #1;
      total++;
      if (phase !== 3'(p)) begin
        bad++;
        $display("FAIL add_phase got=%0d exp=%0d", phase, p);
      end
      total++;
      if (outs !== exp[p]) begin
        bad++;
        $display("FAIL add_outs p=%0d got=%b exp=%b", p, outs, exp[p]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sto();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000000100, 9'b000000000, 9'b000000010, 9'b001000010};
    opcode = 3'd6;
    zero   = 1'b1;
    for (int p = 0; p < 8; p++) begin
      #1;
      total++;
      if (outs !== exp[p] || phase !== 3'(p)) begin
        bad++;
        $display("FAIL sto_outs p=%0d phase=%0d got=%b exp=%b", p, phase, outs, exp[p]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skz(input logic z);
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000000100, 9'b000000000, 9'b000000000, 9'b000000000};
    if (z) exp[6] = 9'b000000100;
    opcode = 3'd1;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      #1;
      total++;
      if (outs !== exp[p] || phase !== 3'(p)) begin
        bad++;
        $display("FAIL skz_outs z=%0b p=%0d phase=%0d got=%b exp=%b", z, p, phase, outs, exp[p]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jmp();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000000100, 9'b000000000, 9'b000001000, 9'b000001100};
    opcode = 3'd7;
    zero   = 1'b0;
    for (int p = 0; p < 8; p++) begin
      #1;
      total++;
      if (outs !== exp[p] || phase !== 3'(p)) begin
        bad++;
        $display("FAIL jmp_outs p=%0d phase=%0d got=%b exp=%b", p, phase, outs, exp[p]);
      end
      @(negedge clk);
    end
  endtask

  // Bus rules across every non-halting opcode and both zero values.
  task automatic test_bus_rules();
    for (int op = 1; op < 8; op++) begin
      for (int z = 0; z < 2; z++) begin
        opcode = 3'(op);
        zero   = z[0];
        for (int p = 0; p < 8; p++) begin
          #1;
          total++;
          if ((rd && wr) || (wr && !data_e) || (data_e && rd)) begin
            bad++;
            $display("FAIL bus_rule op=%0d z=%0d p=%0d got rd=%b wr=%b data_e=%b exp no conflict",
                     op, z, p, rd, wr, data_e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_reset_midcycle();
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      bad++;
      $display("FAIL midrst_async phase=%0d got=%b exp phase=0 outs=%b", phase, outs, 9'b100000000);
    end
    #2;
    rst = 1'b0;
    @(negedge clk);
    for (int p = 1; p < 8; p++) begin
      #1;
      total++;
      if (phase !== 3'(p)) begin
        bad++;
        $display("FAIL midrst_step got=%0d exp=%0d", phase, p);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (phase !== 3'd0) begin
      bad++;
      $display("FAIL midrst_wrap got=%0d exp=0", phase);
    end
  endtask

  task automatic test_halt();
    logic [8:0] exp [5];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000101};
    opcode = 3'd0;
    zero   = 1'b0;
    for (int p = 0; p < 5; p++) begin
      #1;
      total++;
      if (outs !== exp[p] || phase !== 3'(p)) begin
        bad++;
        $display("FAIL hlt_outs p=%0d phase=%0d got=%b exp=%b", p, phase, outs, exp[p]);
      end
      @(negedge clk);
    end
    // Change opcode while halted: the latch must hold regardless.
    opcode = 3'd2;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (phase !== 3'd5 || outs !== 9'b000000001) begin
        bad++;
        $display("FAIL hlt_hold i=%0d phase=%0d got=%b exp phase=5 outs=%b", i, phase, outs, 9'b000000001);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    total++;
    if (phase !== 3'd0 || halt !== 1'b0 || outs !== 9'b100000000) begin
      bad++;
      $display("FAIL hlt_reset phase=%0d got=%b exp phase=0 outs=%b", phase, outs, 9'b100000000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    test_reset();
    test_add();
    test_sto();
    test_skz(1'b1);
    test_skz(1'b0);
    test_jmp();
    test_bus_rules();
    test_reset_midcycle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
